// File: rtl/bram_wb_dp.sv
`default_nettype none
// ============================================================================
// Module   : bram_wb_dp
// Purpose  : Single-clock dual-port block RAM. Port A is a raw fabric port,
//            port B is a Wishbone classic slave with byte selects,
//            programmable read latency, wait states and error responses.
// Ports    : wbs_clk_i / wbs_rst_n_i    - clock, async active-low reset
//            fabric_*                    - port A enable/write/byte-enable/
//                                          word address/data in/data out
//            wbs_cyc_i .. wbs_dat_i      - Wishbone request (byte address)
//            wbs_dat_o/wbs_ack_o/wbs_err_o - registered Wishbone response
// Revision : 1.0 - initial release
// ============================================================================
module bram_wb_dp #(
    parameter int unsigned DEV_BASE_ADDR  = 0,
    parameter int unsigned DEV_HIGH_ADDR  = 4095,
    parameter int          BUS_DATA_WIDTH = 32,
    parameter int          BUS_ADDR_WIDTH = 32,
    parameter int          BUS_BE_WIDTH   = BUS_DATA_WIDTH / 8,
    parameter int          RAM_ADDR_WIDTH = 10,
    parameter int          RD_LATENCY     = 1,
    parameter int          WAIT_STATES    = 0
) (
    input  logic                      wbs_clk_i,
    input  logic                      wbs_rst_n_i,
    input  logic                      fabric_en,
    input  logic                      fabric_we,
    input  logic [BUS_BE_WIDTH-1:0]   fabric_be,
    input  logic [RAM_ADDR_WIDTH-1:0] fabric_addr,
    input  logic [BUS_DATA_WIDTH-1:0] fabric_data_in,
    output logic [BUS_DATA_WIDTH-1:0] fabric_data_out,
    input  logic                      wbs_cyc_i,
    input  logic                      wbs_stb_i,
    input  logic                      wbs_we_i,
    input  logic [BUS_BE_WIDTH-1:0]   wbs_sel_i,
    input  logic [BUS_ADDR_WIDTH-1:0] wbs_adr_i,
    input  logic [BUS_DATA_WIDTH-1:0] wbs_dat_i,
    output logic [BUS_DATA_WIDTH-1:0] wbs_dat_o,
    output logic                      wbs_ack_o,
    output logic                      wbs_err_o
);

    localparam int c_depth    = 2 ** RAM_ADDR_WIDTH;
    localparam int c_lsb      = $clog2(BUS_BE_WIDTH);
    localparam int c_b_stages = (RD_LATENCY > 1) ? RD_LATENCY - 1 : 1;

    localparam logic [BUS_ADDR_WIDTH-1:0] c_base     = BUS_ADDR_WIDTH'(DEV_BASE_ADDR);
    localparam logic [BUS_ADDR_WIDTH-1:0] c_span     = BUS_ADDR_WIDTH'(DEV_HIGH_ADDR - DEV_BASE_ADDR);
    localparam logic [BUS_ADDR_WIDTH-1:0] c_lsb_mask = BUS_ADDR_WIDTH'(BUS_BE_WIDTH - 1);

    localparam logic [4:0] c_wr_cnt = 5'(1 + WAIT_STATES);
    localparam logic [4:0] c_rd_cnt = 5'(RD_LATENCY + WAIT_STATES);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_wait = 2'd1;
    localparam logic [1:0] c_st_resp = 2'd2;

    logic [BUS_DATA_WIDTH-1:0] r_mem [c_depth];

    logic [1:0]                r_state;
    logic [4:0]                r_cnt;
    logic                      r_is_err;
    logic                      r_is_rd;
    logic [BUS_DATA_WIDTH-1:0] r_b_pipe [c_b_stages];
    logic [BUS_DATA_WIDTH-1:0] r_a_data [RD_LATENCY];

    // ------------------------------------------------------------------
    // Address decode. The extra MSB of the subtraction is the borrow, so
    // "below base" and the offset fall out of a single subtract.
    // ------------------------------------------------------------------
    logic [BUS_ADDR_WIDTH:0]   w_off_ext;
    logic [BUS_ADDR_WIDTH-1:0] w_offset;
    logic [BUS_ADDR_WIDTH-1:0] w_word;
    logic [RAM_ADDR_WIDTH-1:0] w_word_idx;
    logic                      w_hit;
    logic                      w_bad;
    logic                      w_b_wr;
    logic                      w_b_rd;
    logic [4:0]                w_tgt;
    logic [BUS_DATA_WIDTH-1:0] w_b_pipe_out;

    assign w_off_ext  = {1'b0, wbs_adr_i} - {1'b0, c_base};
    assign w_offset   = w_off_ext[BUS_ADDR_WIDTH-1:0];
    assign w_word     = w_offset >> c_lsb;
    assign w_word_idx = w_word[RAM_ADDR_WIDTH-1:0];

    assign w_hit = wbs_cyc_i & wbs_stb_i & ~w_off_ext[BUS_ADDR_WIDTH] & (w_offset <= c_span);
    assign w_bad = (|(w_offset & c_lsb_mask)) | (|(w_word >> RAM_ADDR_WIDTH));

    // RAM is touched only on the IDLE accept edge of a well-formed request.
    assign w_b_wr = (r_state == c_st_idle) & w_hit & ~w_bad & wbs_we_i;
    assign w_b_rd = (r_state == c_st_idle) & w_hit & ~w_bad & ~wbs_we_i;

    // Errored requests respond on the write timing.
    assign w_tgt = (wbs_we_i | w_bad) ? c_wr_cnt : c_rd_cnt;

    assign w_b_pipe_out = r_b_pipe[c_b_stages-1];

    // ------------------------------------------------------------------
    // Storage. Port A lanes are assigned last so they win a same-word,
    // same-lane collision; non-overlapping lanes from both ports land.
    // Reads elsewhere sample r_mem before these updates (old data).
    // ------------------------------------------------------------------
    always_ff @(posedge wbs_clk_i) begin
        for (int i = 0; i < BUS_BE_WIDTH; i++) begin
            if (w_b_wr && wbs_sel_i[i])
                r_mem[w_word_idx][i*8 +: 8] <= wbs_dat_i[i*8 +: 8];
            if (fabric_en && fabric_we && fabric_be[i])
                r_mem[fabric_addr][i*8 +: 8] <= fabric_data_in[i*8 +: 8];
        end
    end

    // ------------------------------------------------------------------
    // Port A read pipeline. Each stage loads only when a read is passing
    // through it, so the output holds its last read value.
    // ------------------------------------------------------------------
    logic [RD_LATENCY-1:0] w_a_load;
    assign w_a_load[0] = fabric_en;

    generate
        if (RD_LATENCY > 1) begin : g_a_en_dly
            logic [RD_LATENCY-2:0] r_a_en_d;
            always_ff @(posedge wbs_clk_i or negedge wbs_rst_n_i) begin
                if (!wbs_rst_n_i) begin
                    r_a_en_d <= '0;
                end else begin
                    r_a_en_d[0] <= fabric_en;
                    for (int i = 1; i < RD_LATENCY - 1; i++)
                        r_a_en_d[i] <= r_a_en_d[i-1];
                end
            end
            assign w_a_load[RD_LATENCY-1:1] = r_a_en_d;
        end
    endgenerate

    always_ff @(posedge wbs_clk_i or negedge wbs_rst_n_i) begin
        if (!wbs_rst_n_i) begin
            for (int i = 0; i < RD_LATENCY; i++) r_a_data[i] <= '0;
        end else begin
            if (w_a_load[0]) r_a_data[0] <= r_mem[fabric_addr];
            for (int i = 1; i < RD_LATENCY; i++)
                if (w_a_load[i]) r_a_data[i] <= r_a_data[i-1];
        end
    end

    assign fabric_data_out = r_a_data[RD_LATENCY-1];

    // ------------------------------------------------------------------
    // Port B read pipeline: captured at the accept edge, then shifted.
    // The handshake counter guarantees the last stage is settled by the
    // time wbs_dat_o loads it, so stage 0 only loads on an accepted read.
    // ------------------------------------------------------------------
    always_ff @(posedge wbs_clk_i or negedge wbs_rst_n_i) begin
        if (!wbs_rst_n_i) begin
            for (int i = 0; i < c_b_stages; i++) r_b_pipe[i] <= '0;
        end else begin
            if (w_b_rd) r_b_pipe[0] <= r_mem[w_word_idx];
            for (int i = 1; i < c_b_stages; i++) r_b_pipe[i] <= r_b_pipe[i-1];
        end
    end

    // ------------------------------------------------------------------
    // Handshake FSM. r_cnt holds the cycles remaining until the response
    // cycle; a single-cycle transfer goes straight from IDLE to RESP.
    // ------------------------------------------------------------------
    always_ff @(posedge wbs_clk_i or negedge wbs_rst_n_i) begin
        if (!wbs_rst_n_i) begin
            r_state   <= c_st_idle;
            r_cnt     <= '0;
            r_is_err  <= 1'b0;
            r_is_rd   <= 1'b0;
            wbs_ack_o <= 1'b0;
            wbs_err_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            wbs_ack_o <= 1'b0;
            wbs_err_o <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_hit) begin
                        r_is_err <= w_bad;
                        r_is_rd  <= w_b_rd;
                        if (w_tgt == 5'd1) begin
                            r_state   <= c_st_resp;
                            wbs_ack_o <= ~w_bad;
                            wbs_err_o <= w_bad;
                            if (w_b_rd) wbs_dat_o <= r_mem[w_word_idx];
                        end else begin
                            r_state <= c_st_wait;
                            r_cnt   <= w_tgt - 5'd1;
                        end
                    end
                end
                c_st_wait: begin
                    if (!(wbs_cyc_i && wbs_stb_i)) begin
                        // Master abandoned the cycle: drop it silently.
                        r_state <= c_st_idle;
                    end else if (r_cnt == 5'd1) begin
                        r_state   <= c_st_resp;
                        wbs_ack_o <= ~r_is_err;
                        wbs_err_o <= r_is_err;
                        if (r_is_rd) wbs_dat_o <= w_b_pipe_out;
                    end else begin
                        r_cnt <= r_cnt - 5'd1;
                    end
                end
                c_st_resp: r_state <= c_st_idle;
                default:   r_state <= c_st_idle;
            endcase
        end
    end

endmodule
`default_nettype wire
